// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants, FSM encoding and byte helpers for the audio frame packer
package audio_pkg;

  localparam logic [7:0] AUDIO_SYNC_BYTE = 8'hA5;
  localparam int         AUDIO_SAMPLE_W  = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_CNT  = 3'd2;
  localparam logic [2:0] ST_HI   = 3'd3;
  localparam logic [2:0] ST_LO   = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;

  function automatic logic [7:0] sample_hi(input logic [AUDIO_SAMPLE_W-1:0] s);
    return s[AUDIO_SAMPLE_W-1 -: 8];
  endfunction

  function automatic logic [7:0] sample_lo(input logic [AUDIO_SAMPLE_W-1:0] s);
    return s[7:0];
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - sample FIFO with async head read and a one-ahead peek port
module audio_sample_fifo #(
  parameter int p_width = 16,
  parameter int p_depth = 16,
  localparam int AW = $clog2(p_depth)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [p_width-1:0] wr_data_i,
  input  logic               pop_i,
  output logic [p_width-1:0] rd_data_o,
  output logic [p_width-1:0] rd_next_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [AW:0]        count_o
);

  logic [p_width-1:0] mem_q [p_depth];
  logic [AW:0]        wr_ptr_q;
  logic [AW:0]        rd_ptr_q;
  logic [AW-1:0]      rd_next_idx;

  // Push into a full FIFO is only issued alongside a pop, so the slot being overwritten is the head being retired.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign rd_data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_next_o   = mem_q[rd_next_idx];
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign full_o      = (count_o == (AW+1)'(p_depth));
  assign empty_o     = (count_o == '0);

endmodule

// File: rtl/audio_frame_packer.sv
// rtl/audio_frame_packer.sv - buffers audio samples and emits sync/counter/sample/checksum byte frames
module audio_frame_packer
  import audio_pkg::*;
#(
  parameter int p_frameSamples = 4,
  parameter int p_fifoDepth    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [AUDIO_SAMPLE_W-1:0] i_sample,
  input  logic                      i_sampleValid,
  output logic [7:0]                o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_overflow
);

  localparam int AW = $clog2(p_fifoDepth);

  logic [2:0]                state_q, state_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic [7:0]                csum_q, csum_d;
  logic [7:0]                frame_cnt_q, frame_cnt_d;
  logic [7:0]                idx_q, idx_d;
  logic                      overflow_q;

  logic                      handshake;
  logic                      pop;
  logic                      push;
  logic [AUDIO_SAMPLE_W-1:0] fifo_head;
  logic [AUDIO_SAMPLE_W-1:0] fifo_next;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;

  assign handshake = valid_q && i_ready;
  assign push      = i_sampleValid && (!fifo_full || pop);

  audio_sample_fifo #(
    .p_width(AUDIO_SAMPLE_W),
    .p_depth(p_fifoDepth)
  ) u_fifo (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .push_i   (push),
    .wr_data_i(i_sample),
    .pop_i    (pop),
    .rd_data_o(fifo_head),
    .rd_next_o(fifo_next),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    idx_d       = idx_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && int'(fifo_count) >= p_frameSamples) begin
          state_d = ST_SYNC;
          data_d  = AUDIO_SYNC_BYTE;
          valid_d = 1'b1;
          csum_d  = 8'h00;
          idx_d   = 8'h00;
        end
      end
      ST_SYNC: if (handshake) begin
        state_d = ST_CNT;
        data_d  = frame_cnt_q;
      end
      ST_CNT: if (handshake) begin
        state_d = ST_HI;
        data_d  = sample_hi(fifo_head);
        csum_d  = csum_q ^ data_q;
      end
      ST_HI: if (handshake) begin
        state_d = ST_LO;
        data_d  = sample_lo(fifo_head);
        csum_d  = csum_q ^ data_q;
      end
      ST_LO: if (handshake) begin
        // The head retires on this edge, so the following sample's MSB comes from the peek port.
        pop    = 1'b1;
        csum_d = csum_q ^ data_q;
        if (idx_q < 8'(p_frameSamples - 1)) begin
          state_d = ST_HI;
          idx_d   = idx_q + 8'd1;
          data_d  = sample_hi(fifo_next);
        end else begin
          state_d = ST_CSUM;
          data_d  = csum_q ^ data_q;
        end
      end
      ST_CSUM: if (handshake) begin
        state_d     = ST_IDLE;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      csum_q      <= 8'h00;
      frame_cnt_q <= 8'h00;
      idx_q       <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      if (i_sampleValid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_overflow = overflow_q;

endmodule
